// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package rv32_mem_arbiter_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  // Which requester owns the current transaction.
  typedef enum logic {
    ARB_PORT_INSTR = 1'b0,
    ARB_PORT_DATA  = 1'b1
  } arb_port_e;

  // Request fields presented to memory for the granted port.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_req_t;

  // Width of the instruction anti-starvation counter.
  localparam int unsigned STARVE_CNT_W = 4;

  // Data wins by default; instruction wins when it is alone or has been
  // passed over too many times in a row.
  function automatic arb_port_e arb_pick(input logic i_valid,
                                         input logic d_valid,
                                         input logic starved);
    arb_port_e pick;
    pick = ARB_PORT_DATA;
    if (!d_valid) begin
      pick = ARB_PORT_INSTR;
    end else if (i_valid && starved) begin
      pick = ARB_PORT_INSTR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rv32_arb_timeout.sv
// Clearable saturating watchdog counter. expired pulses in the enabled
// cycle whose increment makes the count reach LIMIT, so the owner can leave
// its waiting states after exactly LIMIT enabled cycles. LIMIT = 0 disables it.
module rv32_arb_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (LIMIT == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, resetn, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_counter
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and hold at LIMIT.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != W'(LIMIT))) begin
        cnt_d = cnt_q + W'(1);
      end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = enable && !clear && (cnt_q == W'(LIMIT - 1));
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports: one
// transaction at a time, data priority with an instruction anti-starvation
// limit, registered request channel, and timeout-to-error completions.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic        m_req_we,
  output logic [31:0] m_req_addr,
  output logic [31:0] m_req_wdata,
  output logic [3:0]  m_req_wstrb,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_data
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              state_q,       state_d;
  arb_port_e               grant_q,       grant_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q,  starve_cnt_d;
  logic                    stale_q,       stale_d;
  arb_req_t                req_q,         req_d;
  logic                    m_req_valid_q, m_req_valid_d;
  logic                    i_done_q,      i_done_d;
  logic [31:0]             i_rdata_q,     i_rdata_d;
  logic                    i_err_q,       i_err_d;
  logic                    d_done_q,      d_done_d;
  logic [31:0]             d_rdata_q,     d_rdata_d;
  logic                    d_err_q,       d_err_d;

  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_expired;
  logic        resp_live;
  logic        cpl_valid;
  logic        cpl_err;
  logic [31:0] cpl_data;

  rv32_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // A response owed to a timed-out transaction is swallowed, never matched.
  assign resp_live = m_resp_valid && !stale_q;

  // Next-state, grant, request latching and completion routing.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    starve_cnt_d  = starve_cnt_q;
    stale_d       = stale_q;
    req_d         = req_q;
    m_req_valid_d = m_req_valid_q;
    i_done_d      = 1'b0;
    i_rdata_d     = '0;
    i_err_d       = 1'b0;
    d_done_d      = 1'b0;
    d_rdata_d     = '0;
    d_err_d       = 1'b0;
    tmo_clear     = 1'b0;
    tmo_enable    = 1'b0;
    cpl_valid     = 1'b0;
    cpl_err       = 1'b0;
    cpl_data      = '0;

    if (m_resp_valid && stale_q) begin
      stale_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (i_req_valid || d_req_valid) begin
          grant_d = arb_pick(i_req_valid, d_req_valid, starve_cnt_q == STARVE_MAX);
          if (grant_d == ARB_PORT_DATA) begin
            req_d.we    = d_req_we;
            req_d.addr  = d_req_addr;
            req_d.wdata = d_req_wdata;
            req_d.wstrb = d_req_wstrb;
            if (i_req_valid) begin
              starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                          : starve_cnt_q + STARVE_CNT_W'(1);
            end else begin
              starve_cnt_d = '0;
            end
          end else begin
            req_d.we     = 1'b0;
            req_d.addr   = i_req_addr;
            req_d.wdata  = '0;
            req_d.wstrb  = '0;
            starve_cnt_d = '0;
          end
          m_req_valid_d = 1'b1;
          tmo_clear     = 1'b1;
          state_d       = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        tmo_enable = 1'b1;
        if (tmo_expired) begin
          // If memory takes the request in the very cycle we give up, its
          // response will still come and must be discarded.
          m_req_valid_d = 1'b0;
          cpl_valid     = 1'b1;
          cpl_err       = 1'b1;
          if (m_req_ready) begin
            stale_d = 1'b1;
          end
          state_d = ARB_RESP;
        end else if (m_req_ready) begin
          m_req_valid_d = 1'b0;
          state_d       = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        tmo_enable = 1'b1;
        if (resp_live) begin
          cpl_valid = 1'b1;
          cpl_data  = req_q.we ? 32'h0 : m_resp_data;
          state_d   = ARB_RESP;
        end else if (tmo_expired) begin
          cpl_valid = 1'b1;
          cpl_err   = 1'b1;
          stale_d   = 1'b1;
          state_d   = ARB_RESP;
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (cpl_valid) begin
      if (grant_q == ARB_PORT_INSTR) begin
        i_done_d  = 1'b1;
        i_rdata_d = cpl_data;
        i_err_d   = cpl_err;
      end else begin
        d_done_d  = 1'b1;
        d_rdata_d = cpl_data;
        d_err_d   = cpl_err;
      end
    end
  end

  // State, request and completion registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ARB_IDLE;
      grant_q       <= ARB_PORT_INSTR;
      starve_cnt_q  <= '0;
      stale_q       <= 1'b0;
      req_q         <= '0;
      m_req_valid_q <= 1'b0;
      i_done_q      <= 1'b0;
      i_rdata_q     <= '0;
      i_err_q       <= 1'b0;
      d_done_q      <= 1'b0;
      d_rdata_q     <= '0;
      d_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      starve_cnt_q  <= starve_cnt_d;
      stale_q       <= stale_d;
      req_q         <= req_d;
      m_req_valid_q <= m_req_valid_d;
      i_done_q      <= i_done_d;
      i_rdata_q     <= i_rdata_d;
      i_err_q       <= i_err_d;
      d_done_q      <= d_done_d;
      d_rdata_q     <= d_rdata_d;
      d_err_q       <= d_err_d;
    end
  end

  assign m_req_valid = m_req_valid_q;
  assign m_req_we    = req_q.we;
  assign m_req_addr  = req_q.addr;
  assign m_req_wdata = req_q.wdata;
  assign m_req_wstrb = req_q.wstrb;
  assign i_done      = i_done_q;
  assign i_rdata     = i_rdata_q;
  assign i_err       = i_err_q;
  assign d_done      = d_done_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Randomized self-checking bench for rv32_mem_arbiter. Requesters and memory
// are modelled per transaction; the expected grant, completion cycle, data
// and error flag come from the arbitration and timeout rules directly.
module tb_rv32_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_req_we;
  logic [31:0] m_req_addr;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_resp_valid;
  logic [31:0] m_resp_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int late_cyc = -1;
  logic [31:0] late_data = '0;

  // Requester-side view of outstanding requests.
  logic        i_pend = 1'b0;
  logic [31:0] i_addr_m = '0;
  logic        d_pend = 1'b0;
  logic        d_we_m = 1'b0;
  logic [31:0] d_addr_m = '0;
  logic [31:0] d_wdata_m = '0;
  logic [3:0]  d_wstrb_m = '0;

  int starve_m    = 0;
  int reload_mode = 0;
  int last_port   = -1;

  rv32_mem_arbiter #(
    .STARVE_LIMIT   (STARVE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_done       (i_done),
    .i_rdata      (i_rdata),
    .i_err        (i_err),
    .d_req_valid  (d_req_valid),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_wstrb  (d_req_wstrb),
    .d_done       (d_done),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_we     (m_req_we),
    .m_req_addr   (m_req_addr),
    .m_req_wdata  (m_req_wdata),
    .m_req_wstrb  (m_req_wstrb),
    .m_resp_valid (m_resp_valid),
    .m_resp_data  (m_resp_data)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one cycle; memory idles except for a scheduled late response.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    m_req_ready  = 1'b0;
    m_resp_valid = (cyc == late_cyc);
    m_resp_data  = (cyc == late_cyc) ? late_data : $urandom();
  endtask

  task automatic applyStimulus();
    i_req_valid = i_pend;
    i_req_addr  = i_pend ? i_addr_m : $urandom();
    d_req_valid = d_pend;
    d_req_we    = d_pend ? d_we_m : 1'($urandom());
    d_req_addr  = d_pend ? d_addr_m : $urandom();
    d_req_wdata = d_pend ? d_wdata_m : $urandom();
    d_req_wstrb = d_pend ? d_wstrb_m : 4'($urandom());
  endtask

  task automatic newInstr();
    i_pend   = 1'b1;
    i_addr_m = {$urandom_range(0, 16'hFFFF), 2'b00};
  endtask

  task automatic newData();
    d_pend    = 1'b1;
    d_we_m    = 1'($urandom_range(0, 1));
    d_addr_m  = $urandom();
    d_wdata_m = $urandom();
    d_wstrb_m = 4'($urandom_range(1, 15));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".m_req_valid"}, 32'(m_req_valid), 32'h0);
    checkOutput({tag, ".m_req_we"},    32'(m_req_we),    32'h0);
    checkOutput({tag, ".m_req_addr"},  m_req_addr,       32'h0);
    checkOutput({tag, ".m_req_wdata"}, m_req_wdata,      32'h0);
    checkOutput({tag, ".m_req_wstrb"}, 32'(m_req_wstrb), 32'h0);
    checkOutput({tag, ".i_done"},      32'(i_done),      32'h0);
    checkOutput({tag, ".i_rdata"},     i_rdata,          32'h0);
    checkOutput({tag, ".i_err"},       32'(i_err),       32'h0);
    checkOutput({tag, ".d_done"},      32'(d_done),      32'h0);
    checkOutput({tag, ".d_rdata"},     d_rdata,          32'h0);
    checkOutput({tag, ".d_err"},       32'(d_err),       32'h0);
  endtask

  // One transaction from the IDLE sampling cycle through the idle cycle after done.
  // mode 0: ready after r cycles, response p cycles after acceptance
  // mode 1: memory never ready -> timeout in ISSUE
  // mode 2: accepted after r cycles, response only after the timeout (late)
  task automatic runTransaction(input int mode, input int r, input int p,
                                input logic [31:0] rsp, input int latek);
    int          g;
    int          ld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_valid;

    if (i_pend && d_pend) g = (starve_m == STARVE) ? 0 : 1;
    else if (d_pend)      g = 1;
    else                  g = 0;
    if (g == 1 && i_pend) starve_m = (starve_m < STARVE) ? starve_m + 1 : STARVE;
    else                  starve_m = 0;

    if (g == 1) begin
      we = d_we_m; addr = d_addr_m; wdata = d_wdata_m; wstrb = d_wstrb_m;
    end else begin
      we = 1'b0; addr = i_addr_m; wdata = 32'h0; wstrb = 4'h0;
    end

    ld        = (mode == 0) ? r + p + 2 : TMO;
    exp_err   = (mode != 0);
    exp_rdata = (mode != 0 || we) ? 32'h0 : rsp;
    if (mode == 2) begin
      late_cyc  = cyc + 1 + ld + latek;
      late_data = rsp;
    end

    for (int k = 0; k <= ld; k++) begin
      tick();
      if (mode != 1 && k == r) m_req_ready = 1'b1;
      if (mode == 0 && k == r + 1 + p) begin
        m_resp_valid = 1'b1;
        m_resp_data  = rsp;
      end
      exp_valid = (k < ld) && (mode == 1 || k <= r);
      checkOutput("m_req_valid", 32'(m_req_valid), 32'(exp_valid));
      if (exp_valid) begin
        checkOutput("m_req_we",    32'(m_req_we),    32'(we));
        checkOutput("m_req_addr",  m_req_addr,       addr);
        checkOutput("m_req_wstrb", 32'(m_req_wstrb), 32'(wstrb));
        if (g == 1) checkOutput("m_req_wdata", m_req_wdata, wdata);
      end
      checkOutput("i_done", 32'(i_done), 32'(k == ld && g == 0));
      checkOutput("d_done", 32'(d_done), 32'(k == ld && g == 1));
      if (k == ld) begin
        last_port = d_done ? 1 : (i_done ? 0 : -1);
        if (g == 0) begin
          checkOutput("i_rdata", i_rdata, exp_rdata);
          checkOutput("i_err",   32'(i_err), 32'(exp_err));
        end else begin
          checkOutput("d_rdata", d_rdata, exp_rdata);
          checkOutput("d_err",   32'(d_err), 32'(exp_err));
        end
      end
    end

    if (reload_mode == 0) begin
      if (g == 0) i_pend = 1'b0; else d_pend = 1'b0;
    end else if (reload_mode == 1) begin
      if (g == 0) newInstr(); else newData();
    end else begin
      if (g == 0) begin
        i_pend = ($urandom_range(0, 2) != 0);
        if (i_pend) newInstr();
      end else begin
        d_pend = ($urandom_range(0, 2) != 0);
        if (d_pend) newData();
      end
      if (!i_pend && $urandom_range(0, 1) == 1) newInstr();
      if (!d_pend && $urandom_range(0, 1) == 1) newData();
      if (!i_pend && !d_pend) begin
        if ($urandom_range(0, 1) == 1) newInstr(); else newData();
      end
    end
    applyStimulus();

    tick();
    checkOutput("idle.m_req_valid", 32'(m_req_valid), 32'h0);
    checkOutput("idle.i_done",      32'(i_done),      32'h0);
    checkOutput("idle.d_done",      32'(d_done),      32'h0);
  endtask

  logic [9:0] order;

  initial begin
    resetn       = 1'b0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    newInstr();
    newData();
    applyStimulus();
    for (int n = 0; n < 3; n++) begin
      tick();
      m_req_ready  = 1'b1;
      m_resp_valid = 1'b1;
    end
    checkAllZero("reset");

    // Single fetch with immediate memory.
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    starve_m     = 0;
    reload_mode  = 0;
    d_pend       = 1'b0;
    i_pend       = 1'b1;
    i_addr_m     = 32'h100;
    applyStimulus();
    resetn = 1'b1;
    runTransaction(0, 0, 0, 32'hDEADBEEF, 0);

    // Data write with explicit fields; read data must come back 0.
    d_pend = 1'b1; d_we_m = 1'b1; d_addr_m = 32'h2000;
    d_wdata_m = 32'h12345678; d_wstrb_m = 4'b0011;
    applyStimulus();
    runTransaction(0, 0, 1, 32'h5555AAAA, 0);

    // Memory never ready: error completion, then a normal fetch.
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h3000;
    d_wdata_m = 32'h0; d_wstrb_m = 4'hF;
    applyStimulus();
    runTransaction(1, 0, 0, 32'h0, 0);
    i_pend = 1'b1; i_addr_m = 32'h104;
    applyStimulus();
    runTransaction(0, 2, 1, 32'h01234567, 0);

    // Accepted but unanswered: late response must be dropped.
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h3004;
    applyStimulus();
    runTransaction(2, 1, 0, 32'hAAAA0000, 2);
    i_pend = 1'b1; i_addr_m = 32'h108;
    applyStimulus();
    runTransaction(0, 0, 0, 32'h0000BBBB, 0);

    // Both ports always busy: four data grants, then one instruction grant.
    reload_mode = 1;
    newInstr();
    newData();
    applyStimulus();
    order = '0;
    for (int n = 0; n < 10; n++) begin
      runTransaction(0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom(), 0);
      order[n] = (last_port == 1);
    end
    checkOutput("grant_order", 32'(order), 32'h1EF);

    // Random traffic with occasional timeouts.
    reload_mode = 2;
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        runTransaction(0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom(), 0);
      else if (sel < 9)
        runTransaction(1, 0, 0, $urandom(), 0);
      else
        runTransaction(2, $urandom_range(0, 3), 0, $urandom(), $urandom_range(0, 2));
    end

    // Reset while waiting for a response.
    reload_mode = 0;
    i_pend = 1'b0;
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h4000;
    applyStimulus();
    tick();
    m_req_ready = 1'b1;
    checkOutput("rst.issue_valid", 32'(m_req_valid), 32'h1);
    tick();
    checkOutput("rst.wait_valid", 32'(m_req_valid), 32'h0);
    resetn = 1'b0;
    tick();
    checkAllZero("midreset");
    resetn = 1'b1;
    d_pend = 1'b0;
    applyStimulus();
    m_resp_valid = 1'b1;
    m_resp_data  = 32'hCCCC0000;
    starve_m     = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("postrst.i_done",      32'(i_done),      32'h0);
      checkOutput("postrst.d_done",      32'(d_done),      32'h0);
      checkOutput("postrst.m_req_valid", 32'(m_req_valid), 32'h0);
    end
    i_pend = 1'b1; i_addr_m = 32'h500;
    applyStimulus();
    runTransaction(0, 1, 2, 32'h600DF00D, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shares one single-port main memory between the core's instruction-fetch port and data port, replacing direct memory wiring in the top level. Accepts one request at a time, arbitrates with data priority plus an instruction anti-starvation limit, and drives a valid/ready request channel toward memory. Routes the response back to the granted port as a one-cycle done pulse with registered read data, and converts stuck memory transactions into error completions.

## Interface
Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while an instruction request waits; range 1..15
- TIMEOUT_CYCLES, 256: cycles in ISSUE or WAIT before error completion; 0 disables timeout

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- i_req_valid  in  1  fetch request; held until i_done
- i_req_addr  in  32  fetch word address
- i_done  out  1  one-cycle completion pulse, fetch port
- i_rdata  out  32  fetch data; valid while i_done
- i_err  out  1  fetch completed by timeout; valid while i_done
- d_req_valid  in  1  data request; held until d_done
- d_req_we  in  1  1 = write
- d_req_addr  in  32  data address
- d_req_wdata  in  32  write data
- d_req_wstrb  in  4  byte enables
- d_done  out  1  one-cycle completion pulse, data port
- d_rdata  out  32  read data (0 for writes); valid while d_done
- d_err  out  1  data completed by timeout; valid while d_done
- m_req_valid  out  1  memory request valid
- m_req_ready  in  1  memory accepts request
- m_req_we, m_req_addr, m_req_wdata, m_req_wstrb  out  1/32/32/4  registered copy of granted request; instruction grants drive we=0, wstrb=0
- m_resp_valid  in  1  memory response; exactly one per accepted request, in order
- m_resp_data  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if no valid request, stay. Otherwise grant, latch granted request fields into m_req_* registers, go ISSUE.
- Grant rule: only one valid -> that port. Both valid -> data, unless starve_cnt == STARVE_LIMIT -> instruction.
- starve_cnt: on data grant with i_req_valid high -> +1 (saturate at STARVE_LIMIT); on instruction grant, or data grant with i_req_valid low -> 0.
- ISSUE: m_req_valid = 1; on m_req_ready -> WAIT. Request fields stable while in ISSUE.
- WAIT: on m_resp_valid -> latch m_resp_data (0 if write), err = 0, go RESP.
- Timeout: tmo_cnt clears on entering ISSUE, increments each ISSUE/WAIT cycle; reaching TIMEOUT_CYCLES -> go RESP with rdata = 0, err = 1. If timeout occurs in WAIT, set stale = 1.
- stale: next m_resp_valid (any state) is discarded and clears stale; it never completes a transaction. m_resp_valid in IDLE/ISSUE/RESP with stale = 0 is ignored.
- RESP: assert done/rdata/err on granted port only for exactly one cycle; requests ignored; go IDLE.
- Requester contract: deassert valid the cycle after sampling done (or present a new request).
- Reset: state IDLE; all outputs 0; starve_cnt, tmo_cnt, stale, grant 0. Reset mid-transaction abandons it; no done issued.

## Timing
- Minimum latency: request valid cycle 0 -> m_req_valid cycle 1 -> (ready cycle 1, resp cycle 2) -> done cycle 3.
- m_req_valid and m_req_* are register outputs; no combinational path from requester inputs to memory outputs.
- done, rdata, err registered; no combinational path m_resp_* -> requester outputs.
- Back-to-back: new grant earliest the cycle after RESP; throughput one transaction per 4 cycles minimum.
- m_resp_valid in the same cycle as m_req_ready (ISSUE) is ignored unless stale = 1.

## Structure
- rv32_types additions: arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}; arb_port_e {ARB_PORT_INSTR, ARB_PORT_DATA}.
- One sub-module: rv32_arb_timeout, a clearable saturating counter with enable, parameter LIMIT, output expired (tied 0 when LIMIT = 0).
- Counter widths: starve_cnt 4 bits; tmo_cnt $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Single fetch addr 0x100, memory ready immediately, resp data 0xDEADBEEF one cycle later -> i_done at cycle 3, i_rdata 0xDEADBEEF, i_err 0, d_done never.
- Both ports valid continuously, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I; no done on wrong port.
- Data write addr 0x2000, wdata 0x12345678, wstrb 0b0011 -> m_req_we 1 with exact fields; d_done with d_rdata 0.
- m_req_ready held 0, TIMEOUT_CYCLES = 8 -> d_done with d_err 1, d_rdata 0, 8 cycles after ISSUE entry; next request proceeds normally.
- Accepted request with no response, TIMEOUT_CYCLES = 8 -> error completion; late resp 0xAAAA0000 discarded; following fetch returns its own 0x0000BBBB.
- Assert resetn low during WAIT -> next cycle IDLE, all outputs 0; late response ignored; no done issued.
